// File: rtl/fas_peak_ctrl_if.sv
// fas_peak_ctrl_if: frame input and peak-result bundle between
// the FFT-side driver and the peak controller.
interface fas_peak_ctrl_if #(
    parameter int DW = 16
);
    logic            fft_valid;
    logic [2*DW-1:0] fft_d0;
    logic [2*DW-1:0] fft_d1;
    logic [2*DW-1:0] fft_d2;
    logic [2*DW-1:0] fft_d3;
    logic [2*DW-1:0] fft_d4;
    logic [2*DW-1:0] fft_d5;
    logic [2*DW-1:0] fft_d6;
    logic [2*DW-1:0] fft_d7;
    logic [2*DW-1:0] fft_d8;
    logic [2*DW-1:0] fft_d9;
    logic [2*DW-1:0] fft_d10;
    logic [2*DW-1:0] fft_d11;
    logic [2*DW-1:0] fft_d12;
    logic [2*DW-1:0] fft_d13;
    logic [2*DW-1:0] fft_d14;
    logic [2*DW-1:0] fft_d15;
    logic            busy;
    logic            done;
    logic [3:0]      freq;
    logic [2*DW-1:0] peak_mag;
    logic            overrun;

    modport master (
        output fft_valid,
        output fft_d0, fft_d1, fft_d2, fft_d3,
        output fft_d4, fft_d5, fft_d6, fft_d7,
        output fft_d8, fft_d9, fft_d10, fft_d11,
        output fft_d12, fft_d13, fft_d14, fft_d15,
        input  busy, done, freq, peak_mag, overrun
    );

    modport slave (
        input  fft_valid,
        input  fft_d0, fft_d1, fft_d2, fft_d3,
        input  fft_d4, fft_d5, fft_d6, fft_d7,
        input  fft_d8, fft_d9, fft_d10, fft_d11,
        input  fft_d12, fft_d13, fft_d14, fft_d15,
        output busy, done, freq, peak_mag, overrun
    );
endinterface

// File: rtl/fas_peak_ctrl.sv
// fas_peak_ctrl: captures one 16-bin FFT frame and scans it through a
// single shared squared-magnitude datapath to report the dominant bin.
module fas_peak_ctrl #(
    parameter bit SKIP_DC = 1'b0,
    parameter int DW      = 16
) (
    input logic            clk,
    input logic            rst,
    fas_peak_ctrl_if.slave bus
);
    localparam int WW = 2 * DW;

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_e;

    state_e        state_q, state_d;
    logic [WW-1:0] buf_q [16];
    logic [WW-1:0] buf_d [16];
    logic [WW-1:0] frame [16];
    logic [3:0]    idx_q, idx_d;
    logic [WW-1:0] mag_q, mag_d;
    logic [3:0]    mag_idx_q, mag_idx_d;
    logic          cmp_vld_q, cmp_vld_d;
    logic [WW-1:0] max_q, max_d;
    logic [3:0]    max_idx_q, max_idx_d;
    logic [3:0]    freq_q, freq_d;
    logic [WW-1:0] peak_q, peak_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          overrun_q, overrun_d;

    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic signed [WW-1:0] re_sq;
    logic signed [WW-1:0] im_sq;
    logic [WW-1:0]        mag_new;
    logic                 accept;

    always_comb begin
        frame[0]  = bus.fft_d0;
        frame[1]  = bus.fft_d1;
        frame[2]  = bus.fft_d2;
        frame[3]  = bus.fft_d3;
        frame[4]  = bus.fft_d4;
        frame[5]  = bus.fft_d5;
        frame[6]  = bus.fft_d6;
        frame[7]  = bus.fft_d7;
        frame[8]  = bus.fft_d8;
        frame[9]  = bus.fft_d9;
        frame[10] = bus.fft_d10;
        frame[11] = bus.fft_d11;
        frame[12] = bus.fft_d12;
        frame[13] = bus.fft_d13;
        frame[14] = bus.fft_d14;
        frame[15] = bus.fft_d15;
    end

    // Squares of signed components are non-negative, so their sum
    // (at most 2^31) fits unsigned in WW bits.
    assign re      = $signed(buf_q[idx_q][WW-1:DW]);
    assign im      = $signed(buf_q[idx_q][DW-1:0]);
    assign re_sq   = WW'(re) * WW'(re);
    assign im_sq   = WW'(im) * WW'(im);
    assign mag_new = $unsigned(re_sq) + $unsigned(im_sq);

    assign accept = bus.fft_valid &&
                    (state_q == IDLE || state_q == DONE);

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        idx_d     = idx_q;
        mag_d     = mag_q;
        mag_idx_d = mag_idx_q;
        cmp_vld_d = cmp_vld_q;
        max_d     = max_q;
        max_idx_d = max_idx_q;
        freq_d    = freq_q;
        peak_d    = peak_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;

        // Strict compare keeps the lowest index on ties.
        if (cmp_vld_q && mag_q > max_q) begin
            max_d     = mag_q;
            max_idx_d = mag_idx_q;
        end

        unique case (state_q)
            IDLE: ;
            SCAN: begin
                mag_d     = mag_new;
                mag_idx_d = idx_q;
                cmp_vld_d = 1'b1;
                idx_d     = idx_q + 4'd1;
                if (SKIP_DC && idx_q == 4'd0)
                    mag_d = '0;
                if (idx_q == 4'd15)
                    state_d = FLUSH;
                if (bus.fft_valid)
                    overrun_d = 1'b1;
            end
            FLUSH: begin
                cmp_vld_d = 1'b0;
                state_d   = DONE;
                if (bus.fft_valid)
                    overrun_d = 1'b1;
            end
            DONE: begin
                freq_d  = max_idx_q;
                peak_d  = max_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            buf_d     = frame;
            idx_d     = '0;
            max_d     = '0;
            max_idx_d = '0;
            cmp_vld_d = 1'b0;
            state_d   = SCAN;
        end

        busy_d = (state_d == SCAN) || (state_d == FLUSH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            for (int i = 0; i < 16; i++)
                buf_q[i] <= '0;
            idx_q     <= '0;
            mag_q     <= '0;
            mag_idx_q <= '0;
            cmp_vld_q <= 1'b0;
            max_q     <= '0;
            max_idx_q <= '0;
            freq_q    <= '0;
            peak_q    <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            idx_q     <= idx_d;
            mag_q     <= mag_d;
            mag_idx_q <= mag_idx_d;
            cmp_vld_q <= cmp_vld_d;
            max_q     <= max_d;
            max_idx_q <= max_idx_d;
            freq_q    <= freq_d;
            peak_q    <= peak_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.freq     = freq_q;
    assign bus.peak_mag = peak_q;
    assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_fas_peak_ctrl.sv
// tb_fas_peak_ctrl: drives frames into two controllers (SKIP_DC 0/1)
// and checks results against a plain-arithmetic peak model.
module tb_fas_peak_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fas_peak_ctrl_if #(.DW(16)) bus0 ();
    fas_peak_ctrl_if #(.DW(16)) bus1 ();

    fas_peak_ctrl #(.SKIP_DC(1'b0), .DW(16)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0));
    fas_peak_ctrl #(.SKIP_DC(1'b1), .DW(16)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1));

    logic [31:0] din [16];
    logic        vin = 1'b0;
    logic [31:0] frm [16];

    assign bus0.fft_valid = vin;
    assign bus1.fft_valid = vin;
    assign bus0.fft_d0  = din[0];
    assign bus0.fft_d1  = din[1];
    assign bus0.fft_d2  = din[2];
    assign bus0.fft_d3  = din[3];
    assign bus0.fft_d4  = din[4];
    assign bus0.fft_d5  = din[5];
    assign bus0.fft_d6  = din[6];
    assign bus0.fft_d7  = din[7];
    assign bus0.fft_d8  = din[8];
    assign bus0.fft_d9  = din[9];
    assign bus0.fft_d10 = din[10];
    assign bus0.fft_d11 = din[11];
    assign bus0.fft_d12 = din[12];
    assign bus0.fft_d13 = din[13];
    assign bus0.fft_d14 = din[14];
    assign bus0.fft_d15 = din[15];
    assign bus1.fft_d0  = din[0];
    assign bus1.fft_d1  = din[1];
    assign bus1.fft_d2  = din[2];
    assign bus1.fft_d3  = din[3];
    assign bus1.fft_d4  = din[4];
    assign bus1.fft_d5  = din[5];
    assign bus1.fft_d6  = din[6];
    assign bus1.fft_d7  = din[7];
    assign bus1.fft_d8  = din[8];
    assign bus1.fft_d9  = din[9];
    assign bus1.fft_d10 = din[10];
    assign bus1.fft_d11 = din[11];
    assign bus1.fft_d12 = din[12];
    assign bus1.fft_d13 = din[13];
    assign bus1.fft_d14 = din[14];
    assign bus1.fft_d15 = din[15];

    int checks = 0;
    int errors = 0;

    int          lat0, lat1, busy_n, pulses0, pulses1;
    logic [3:0]  f0, f1;
    logic [31:0] p0, p1;

    function automatic logic [31:0] cplx(input int re, input int im);
        return {16'(re), 16'(im)};
    endfunction

    function automatic void ref_peak(input bit skip,
                                     output logic [3:0] fq,
                                     output logic [31:0] pk);
        longint best = 0;
        fq = 4'd0;
        for (int k = 0; k < 16; k++) begin
            longint re = longint'($signed(frm[k][31:16]));
            longint im = longint'($signed(frm[k][15:0]));
            longint m = re * re + im * im;
            if (skip && k == 0) m = 0;
            if (m > best) begin
                best = m;
                fq = 4'(k);
            end
        end
        pk = 32'(best);
    endfunction

    task automatic clear_frm();
        for (int k = 0; k < 16; k++) frm[k] = 32'd0;
    endtask

    task automatic launch();
        @(negedge clk);
        din = frm;
        vin = 1'b1;
    endtask

    // k counts negedges after the capture edge; done is due at k=18.
    task automatic observe(input int ncyc);
        lat0 = -1; lat1 = -1; busy_n = 0;
        pulses0 = 0; pulses1 = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (k == 0) vin = 1'b0;
            if (bus0.busy) busy_n++;
            if (bus0.done) begin
                pulses0++;
                if (lat0 < 0) begin
                    lat0 = k; f0 = bus0.freq; p0 = bus0.peak_mag;
                end
            end
            if (bus1.done) begin
                pulses1++;
                if (lat1 < 0) begin
                    lat1 = k; f1 = bus1.freq; p1 = bus1.peak_mag;
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [38:0] o0, o1;
        rst = 1'b0;
        vin = 1'b0;
        for (int k = 0; k < 16; k++) din[k] = 32'd0;
        repeat (3) @(negedge clk);
        o0 = {bus0.busy, bus0.done, bus0.freq, bus0.peak_mag, bus0.overrun};
        o1 = {bus1.busy, bus1.done, bus1.freq, bus1.peak_mag, bus1.overrun};
        checks++;
        if (o0 !== 39'd0) begin
            errors++; $display("FAIL reset_outs0 got %h want 0", o0);
        end
        checks++;
        if (o1 !== 39'd0) begin
            errors++; $display("FAIL reset_outs1 got %h want 0", o1);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_tone();
        clear_frm();
        frm[5] = cplx(1000, 0);
        launch();
        observe(24);
        checks++;
        if (lat0 !== 18) begin
            errors++; $display("FAIL tone_latency got %0d want 18", lat0);
        end
        checks++;
        if (busy_n !== 17) begin
            errors++; $display("FAIL tone_busy got %0d want 17", busy_n);
        end
        checks++;
        if (pulses0 !== 1) begin
            errors++; $display("FAIL tone_pulses got %0d want 1", pulses0);
        end
        checks++;
        if (f0 !== 4'd5 || p0 !== 32'd1000000) begin
            errors++;
            $display("FAIL tone_result got %0d/%0d want 5/1000000", f0, p0);
        end
        checks++;
        if (f1 !== 4'd5 || p1 !== 32'd1000000) begin
            errors++;
            $display("FAIL tone_result_skip got %0d/%0d want 5/1000000", f1, p1);
        end
    endtask

    task automatic test_tie_signs();
        for (int k = 0; k < 16; k++) frm[k] = cplx(1, 1);
        frm[3] = cplx(-300, 400);
        frm[9] = cplx(500, 0);
        launch();
        observe(24);
        checks++;
        if (lat0 !== 18 || f0 !== 4'd3 || p0 !== 32'd250000) begin
            errors++;
            $display("FAIL tie_result got lat %0d %0d/%0d want 18 3/250000",
                     lat0, f0, p0);
        end
        checks++;
        if (f1 !== 4'd3 || p1 !== 32'd250000) begin
            errors++;
            $display("FAIL tie_result_skip got %0d/%0d want 3/250000", f1, p1);
        end
    endtask

    task automatic test_worst_case();
        clear_frm();
        frm[0]  = cplx(32767, 32767);
        frm[15] = cplx(-32768, -32768);
        launch();
        observe(24);
        checks++;
        if (f0 !== 4'd15 || p0 !== 32'h8000_0000) begin
            errors++;
            $display("FAIL worst_result got %0d/%h want 15/80000000", f0, p0);
        end
        checks++;
        if (f1 !== 4'd15 || p1 !== 32'h8000_0000) begin
            errors++;
            $display("FAIL worst_result_skip got %0d/%h want 15/80000000", f1, p1);
        end
    endtask

    task automatic test_skip_dc();
        clear_frm();
        frm[0] = cplx(20000, 0);
        frm[2] = cplx(10, 10);
        launch();
        observe(24);
        checks++;
        if (f0 !== 4'd0 || p0 !== 32'd400000000) begin
            errors++;
            $display("FAIL dc_kept got %0d/%0d want 0/400000000", f0, p0);
        end
        checks++;
        if (lat1 !== 18 || f1 !== 4'd2 || p1 !== 32'd200) begin
            errors++;
            $display("FAIL dc_skipped got lat %0d %0d/%0d want 18 2/200",
                     lat1, f1, p1);
        end
    endtask

    task automatic test_random();
        logic [3:0]  ef0, ef1;
        logic [31:0] ep0, ep1;
        for (int n = 0; n < 12; n++) begin
            for (int k = 0; k < 16; k++) begin
                case ($urandom_range(0, 3))
                    0: frm[k] = $urandom;
                    1: frm[k] = cplx($urandom_range(0, 6) - 3,
                                     $urandom_range(0, 6) - 3);
                    2: frm[k] = 32'd0;
                    default: frm[k] = cplx(
                        $urandom_range(0, 1) ? 32767 : -32768,
                        $urandom_range(0, 1) ? 32767 : -32768);
                endcase
            end
            ref_peak(1'b0, ef0, ep0);
            ref_peak(1'b1, ef1, ep1);
            launch();
            observe(24);
            checks++;
            if (lat0 !== 18 || f0 !== ef0 || p0 !== ep0) begin
                errors++;
                $display("FAIL rand%0d_dc got lat %0d %0d/%h want 18 %0d/%h",
                         n, lat0, f0, p0, ef0, ep0);
            end
            checks++;
            if (lat1 !== 18 || f1 !== ef1 || p1 !== ep1) begin
                errors++;
                $display("FAIL rand%0d_skip got lat %0d %0d/%h want 18 %0d/%h",
                         n, lat1, f1, p1, ef1, ep1);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          dk [$];
        logic [3:0]  df [$];
        logic [31:0] dp [$];
        logic        busy18 = 1'b0;
        checks++;
        if (bus0.overrun !== 1'b0 || bus1.overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_pre got %b%b want 00", bus0.overrun, bus1.overrun);
        end
        clear_frm();
        frm[7] = cplx(5000, -5000);
        launch();
        for (int k = 0; k < 46; k++) begin
            @(negedge clk);
            if (bus0.done) begin
                dk.push_back(k); df.push_back(bus0.freq);
                dp.push_back(bus0.peak_mag);
            end
            if (k == 18) busy18 = bus0.busy;
            if (k == 0 || k == 5 || k == 18) vin = 1'b0;
            if (k == 4) begin
                for (int j = 0; j < 16; j++) din[j] = 32'd0;
                din[1] = cplx(30000, 30000);
                vin = 1'b1;
            end
            if (k == 17) begin
                for (int j = 0; j < 16; j++) din[j] = 32'd0;
                din[12] = cplx(-20000, 7);
                vin = 1'b1;
            end
        end
        checks++;
        if (dk.size() !== 2) begin
            errors++; $display("FAIL b2b_pulses got %0d want 2", dk.size());
        end else begin
            checks++;
            if (dk[0] !== 18 || df[0] !== 4'd7 || dp[0] !== 32'd50000000) begin
                errors++;
                $display("FAIL b2b_first got k%0d %0d/%0d want k18 7/50000000",
                         dk[0], df[0], dp[0]);
            end
            checks++;
            if (dk[1] !== 36 || df[1] !== 4'd12 || dp[1] !== 32'd400000049) begin
                errors++;
                $display("FAIL b2b_second got k%0d %0d/%0d want k36 12/400000049",
                         dk[1], df[1], dp[1]);
            end
        end
        checks++;
        if (busy18 !== 1'b1) begin
            errors++; $display("FAIL b2b_no_idle got busy %b want 1", busy18);
        end
        checks++;
        if (bus0.overrun !== 1'b1 || bus1.overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sticky got %b%b want 11", bus0.overrun, bus1.overrun);
        end
    endtask

    task automatic test_async_reset();
        logic [38:0] o0, o1;
        clear_frm();
        frm[9] = cplx(123, 456);
        launch();
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k == 0) vin = 1'b0;
        end
        #1 rst = 1'b0;
        #1;
        o0 = {bus0.busy, bus0.done, bus0.freq, bus0.peak_mag, bus0.overrun};
        o1 = {bus1.busy, bus1.done, bus1.freq, bus1.peak_mag, bus1.overrun};
        checks++;
        if (o0 !== 39'd0 || o1 !== 39'd0) begin
            errors++;
            $display("FAIL arst_outs got %h/%h want 0/0", o0, o1);
        end
        #2 rst = 1'b1;
        observe(25);
        checks++;
        if (pulses0 !== 0 || pulses1 !== 0) begin
            errors++;
            $display("FAIL arst_no_done got %0d/%0d want 0/0", pulses0, pulses1);
        end
        clear_frm();
        frm[11] = cplx(-777, 3);
        frm[4]  = cplx(700, 0);
        launch();
        observe(24);
        checks++;
        if (lat0 !== 18 || f0 !== 4'd11 || p0 !== 32'd603738) begin
            errors++;
            $display("FAIL arst_fresh got lat %0d %0d/%0d want 18 11/603738",
                     lat0, f0, p0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_tone();
        test_tie_signs();
        test_worst_case();
        test_skip_dc();
        test_random();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
